spike_generator_array: RTL and testbench

- Time-multiplexed array of up to 2**Ngens periodic spike generators, one shared state RAM.
- On each FPGA time-unit pulse the block scans generators 0..gens_used. Each enabled generator that expires emits its tag on a TagCt output channel.
- Programming arrives on a SpikeGeneratorProg-style channel.
- Successor to the fixed generator: runtime gens_used/gens_en, output backpressure, a queue of pending time units, and an overrun flag.

---
 rtl/spike_gen_pkg.sv | 41 ++++
 rtl/spike_generator_array_ram.sv | 37 +++
 rtl/spike_generator_array.sv | 214 +++++++++++++++++++++
 tb/tb_spike_generator_array.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_gen_pkg.sv
// ----------------------------------------------------------------------------
// spike_gen_pkg
//   Shared types and constants for the time-multiplexed spike generator array.
//
//   Contents:
//     - default widths for the generator array parameters
//     - gen_entry_t : one generator's state word {period, ticks, tag}
//     - state_t     : scan FSM encoding {IDLE, READ, EVAL, EMIT, NEXT}
//     - entry_width : width of a state RAM word for given field widths
// ----------------------------------------------------------------------------
package spike_gen_pkg;

    localparam int NGENS_DEF   = 8;   // generator index width
    localparam int NPERIOD_DEF = 16;  // period / ticks width
    localparam int NTAG_DEF    = 11;  // output tag width
    localparam int NCT_DEF     = 9;   // output count width
    localparam int NPEND_DEF   = 4;   // pending time-unit counter width

    // One generator's state word at the default widths. The field order
    // matches the packing used in the state RAM: period in the MSBs, tag in
    // the LSBs.
    typedef struct packed {
        logic [NPERIOD_DEF-1:0] period;  // reload value, 0 disables
        logic [NPERIOD_DEF-1:0] ticks;   // countdown to next spike
        logic [NTAG_DEF-1:0]    tag;     // tag emitted on expiry
    } gen_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_EVAL = 3'd2,
        ST_EMIT = 3'd3,
        ST_NEXT = 3'd4
    } state_t;

    // Width of one state RAM word: period + ticks + tag.
    function automatic int entry_width(input int nperiod, input int ntag);
        return 2 * nperiod + ntag;
    endfunction

endpackage : spike_gen_pkg

// File: rtl/spike_generator_array_ram.sv
// ----------------------------------------------------------------------------
// gen_state_ram
//   Single-port synchronous RAM holding one state word per generator.
//   A write and a read share the address; the read data appears one cycle
//   after the address is presented (read-before-write on the same address).
//
//   Ports:
//     clk    in   system clock
//     we     in   write enable
//     addr   in   [Aw-1:0] entry address
//     wdata  in   [Dw-1:0] write data
//     rdata  out  [Dw-1:0] registered read data
// ----------------------------------------------------------------------------
module gen_state_ram #(
    parameter int Aw = 8,
    parameter int Dw = 43
) (
    input  logic          clk,
    input  logic          we,
    input  logic [Aw-1:0] addr,
    input  logic [Dw-1:0] wdata,
    output logic [Dw-1:0] rdata
);

    logic [Dw-1:0] mem [2**Aw];

    // NOTE: the storage array has no reset; clearing it would need one write
    // per entry and would stop it mapping onto block RAM. Contents persist
    // across the controller's reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule : gen_state_ram

// File: rtl/spike_generator_array.sv
// ----------------------------------------------------------------------------
// spike_generator_array
//   Time-multiplexed array of up to 2**Ngens periodic spike generators sharing
//   one state RAM. Each time_unit pulse queues one scan of generators
//   0..gens_used. Every enabled generator whose countdown expires emits its
//   tag (with count 1) on the out channel; the scan stalls while the output is
//   not accepted, and pulses arriving meanwhile are counted in a saturating
//   pending counter. Saturation sets the sticky overrun flag.
//
//   Ports:
//     clk           in   system clock
//     reset         in   synchronous active-high reset
//     time_unit     in   one-cycle pulse per wall-clock time unit
//     gens_used     in   [Ngens-1:0]     highest generator index scanned
//     gens_en       in   [2**Ngens-1:0]  per-generator enable
//     prog_gen_idx  in   [Ngens-1:0]     entry to write
//     prog_period   in   [Nperiod-1:0]   reload period, 0 disables
//     prog_ticks    in   [Nperiod-1:0]   initial countdown
//     prog_tag      in   [Ntag-1:0]      tag emitted
//     prog_v        in   program valid
//     prog_a        out  program accepted (only while idle)
//     out_tag       out  [Ntag-1:0]     emitted tag
//     out_ct        out  [Nct-1:0]      spike count, always 1
//     out_v         out  output valid
//     out_a         in   output accept
//     overrun       out  sticky: pending counter saturated
//     busy          out  scan in progress
// ----------------------------------------------------------------------------
module spike_generator_array
    import spike_gen_pkg::*;
#(
    parameter int Ngens   = NGENS_DEF,
    parameter int Nperiod = NPERIOD_DEF,
    parameter int Ntag    = NTAG_DEF,
    parameter int Nct     = NCT_DEF,
    parameter int Npend   = NPEND_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 time_unit,
    input  logic [Ngens-1:0]     gens_used,
    input  logic [2**Ngens-1:0]  gens_en,
    input  logic [Ngens-1:0]     prog_gen_idx,
    input  logic [Nperiod-1:0]   prog_period,
    input  logic [Nperiod-1:0]   prog_ticks,
    input  logic [Ntag-1:0]      prog_tag,
    input  logic                 prog_v,
    output logic                 prog_a,
    output logic [Ntag-1:0]      out_tag,
    output logic [Nct-1:0]       out_ct,
    output logic                 out_v,
    input  logic                 out_a,
    output logic                 overrun,
    output logic                 busy
);

    localparam int Ew = entry_width(Nperiod, Ntag);

    localparam logic [2:0] IDLE = ST_IDLE;
    localparam logic [2:0] READ = ST_READ;
    localparam logic [2:0] EVAL = ST_EVAL;
    localparam logic [2:0] EMIT = ST_EMIT;
    localparam logic [2:0] NEXT = ST_NEXT;

    localparam logic [Npend-1:0] PEND_MAX = '1;

    logic [2:0]         state;
    logic [Ngens-1:0]   idx;
    logic [Npend-1:0]   pending;

    logic               ram_we;
    logic [Ngens-1:0]   ram_addr;
    logic [Ew-1:0]      ram_wdata;
    logic [Ew-1:0]      ram_rdata;

    logic [Nperiod-1:0] rd_period;
    logic [Nperiod-1:0] rd_ticks;
    logic [Ntag-1:0]    rd_tag;
    logic [Nperiod-1:0] ticks_dec;
    logic               gen_live;
    logic               expire;
    logic               scan_start;

    // ------------------------------------------------------------------
    // State RAM word fields (valid during EVAL, read addressed in READ)
    // ------------------------------------------------------------------
    assign rd_period = ram_rdata[Ew-1 -: Nperiod];
    assign rd_ticks  = ram_rdata[Ntag +: Nperiod];
    assign rd_tag    = ram_rdata[Ntag-1:0];
    assign ticks_dec = rd_ticks - 1'b1;

    // A generator takes part only when enabled and given a non-zero period.
    // ticks of 0 counts as 1 so the decrement below can never wrap.
    assign gen_live = gens_en[idx] && (rd_period != '0);
    assign expire   = (rd_ticks <= Nperiod'(1));

    // Programming is only accepted while idle and wins over starting a scan.
    assign prog_a     = !reset && (state == IDLE) && prog_v;
    assign scan_start = (state == IDLE) && !prog_a && ((pending != '0) || time_unit);

    assign busy = (state != IDLE);

    // ------------------------------------------------------------------
    // RAM port: programming writes in IDLE, countdown write-back in EVAL,
    // otherwise the port reads entry idx.
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves one unassigned (which would infer a latch).
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = idx;
        ram_wdata = {rd_period, ticks_dec, rd_tag};
        case (state)
            IDLE: begin
                if (prog_a) begin
                    ram_we    = 1'b1;
                    ram_addr  = prog_gen_idx;
                    ram_wdata = {prog_period, prog_ticks, prog_tag};
                end
            end
            EVAL: begin
                if (gen_live && !reset) begin
                    ram_we    = 1'b1;
                    ram_wdata = expire ? {rd_period, rd_period, rd_tag}
                                       : {rd_period, ticks_dec, rd_tag};
                end
            end
            default: ;
        endcase
    end

    gen_state_ram #(
        .Aw (Ngens),
        .Dw (Ew)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Pending counter, overrun flag, scan FSM and output register
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            pending <= '0;
            overrun <= 1'b0;
            out_v   <= 1'b0;
            out_tag <= '0;
            out_ct  <= '0;
        end else begin
            // A pulse that coincides with a scan start cancels out; that is
            // also the only way a scan starts with pending at zero, so the
            // decrement cannot underflow.
            if (time_unit && !scan_start) begin
                if (pending == PEND_MAX) begin
                    overrun <= 1'b1;
                end else begin
                    pending <= pending + 1'b1;
                end
            end else if (!time_unit && scan_start) begin
                pending <= pending - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (scan_start) begin
                        idx   <= '0;
                        state <= READ;
                    end
                end
                READ: begin
                    state <= EVAL;
                end
                EVAL: begin
                    if (gen_live && expire) begin
                        out_tag <= rd_tag;
                        out_ct  <= Nct'(1);
                        out_v   <= 1'b1;
                        state   <= EMIT;
                    end else begin
                        state <= NEXT;
                    end
                end
                EMIT: begin
                    if (out_a) begin
                        out_v <= 1'b0;
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    // >= rather than == so a gens_used lowered below idx
                    // mid-scan ends the scan instead of letting idx wrap.
                    if (idx >= gens_used) begin
                        state <= IDLE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= READ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : spike_generator_array

// File: tb/tb_spike_generator_array.sv
// ----------------------------------------------------------------------------
// tb_spike_generator_array
//   Directed bench for spike_generator_array. Expected tags are pushed into a
//   scoreboard queue as stimulus is issued; a monitor pops and compares on
//   every output transfer.
// ----------------------------------------------------------------------------
module tb_spike_generator_array;
    import spike_gen_pkg::*;

    localparam int NGENS   = NGENS_DEF;
    localparam int NPERIOD = NPERIOD_DEF;
    localparam int NTAG    = NTAG_DEF;
    localparam int NCT     = NCT_DEF;
    localparam int NPEND   = NPEND_DEF;

    logic                clk;
    logic                reset;
    logic                time_unit;
    logic [NGENS-1:0]    gens_used;
    logic [2**NGENS-1:0] gens_en;
    logic [NGENS-1:0]    prog_gen_idx;
    logic [NPERIOD-1:0]  prog_period;
    logic [NPERIOD-1:0]  prog_ticks;
    logic [NTAG-1:0]     prog_tag;
    logic                prog_v;
    logic                prog_a;
    logic [NTAG-1:0]     out_tag;
    logic [NCT-1:0]      out_ct;
    logic                out_v;
    logic                out_a;
    logic                overrun;
    logic                busy;

    int total = 0;
    int bad   = 0;
    logic [NTAG-1:0] sb [$];

    spike_generator_array #(
        .Ngens   (NGENS),
        .Nperiod (NPERIOD),
        .Ntag    (NTAG),
        .Nct     (NCT),
        .Npend   (NPEND)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .time_unit    (time_unit),
        .gens_used    (gens_used),
        .gens_en      (gens_en),
        .prog_gen_idx (prog_gen_idx),
        .prog_period  (prog_period),
        .prog_ticks   (prog_ticks),
        .prog_tag     (prog_tag),
        .prog_v       (prog_v),
        .prog_a       (prog_a),
        .out_tag      (out_tag),
        .out_ct       (out_ct),
        .out_v        (out_v),
        .out_a        (out_a),
        .overrun      (overrun),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares each transfer against the scoreboard head, and the
    // held tag against it while stalled.
    always @(negedge clk) begin
        if (!reset && out_v) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got tag 0x%0h, expected no output", out_tag);
            end else if (out_a) begin
                check("out_tag", 32'(out_tag), 32'(sb[0]));
                check("out_ct", 32'(out_ct), 1);
                void'(sb.pop_front());
            end else begin
                check("stall_tag", 32'(out_tag), 32'(sb[0]));
            end
        end
    end

    function automatic gen_entry_t mk(input int period, input int ticks, input int tag);
        gen_entry_t e;
        e.period = NPERIOD'(period);
        e.ticks  = NPERIOD'(ticks);
        e.tag    = NTAG'(tag);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        time_unit = 1'b1;
        step();
        time_unit = 1'b0;
    endtask

    // Offers one program word; while a scan runs, prog_a must stay low.
    task automatic program_gen(input int i, input gen_entry_t e);
        bit accepted = 1'b0;
        prog_gen_idx = NGENS'(i);
        prog_period  = e.period;
        prog_ticks   = e.ticks;
        prog_tag     = e.tag;
        prog_v       = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (busy) check("prog_a_busy", 32'(prog_a), 0);
            else if (prog_a) accepted = 1'b1;
            step();
            if (accepted) break;
        end
        prog_v = 1'b0;
        if (!accepted) check("prog_timeout", 0, 1);
    endtask

    // Waits until the block is idle with every expected tag delivered.
    task automatic wait_idle(input int budget);
        int quiet = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) quiet++;
            else quiet = 0;
            if (quiet >= 3) break;
        end
        step();
        check("drain_idle", 32'(quiet >= 3), 1);
        sb.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
    endtask

    initial begin
        reset        = 1'b1;
        time_unit    = 1'b0;
        gens_used    = '0;
        gens_en      = '0;
        prog_gen_idx = '0;
        prog_period  = '0;
        prog_ticks   = '0;
        prog_tag     = '0;
        prog_v       = 1'b1;
        out_a        = 1'b1;

        // Reset state; prog_a must stay low under reset even with prog_v set
        step();
        @(negedge clk);
        check("rst_prog_a", 32'(prog_a), 0);
        check("rst_out_v", 32'(out_v), 0);
        check("rst_out_tag", 32'(out_tag), 0);
        check("rst_out_ct", 32'(out_ct), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_busy", 32'(busy), 0);
        prog_v = 1'b0;
        step();
        reset = 1'b0;

        // Basic period 3, ticks 1: emits on units 1, 4, 7
        gens_used  = '0;
        gens_en    = '0;
        gens_en[0] = 1'b1;
        program_gen(0, mk(3, 1, 'h2A));
        sb.push_back(NTAG'('h2A));
        pulse();
        @(negedge clk);
        check("lat_read", 32'(out_v), 0);
        step();
        @(negedge clk);
        check("lat_eval", 32'(out_v), 0);
        step();
        @(negedge clk);
        check("lat_emit", 32'(out_v), 1);
        step();
        wait_idle(1500);
        for (int u = 2; u <= 9; u++) begin
            if (u % 3 == 1) sb.push_back(NTAG'('h2A));
            pulse();
            wait_idle(1500);
        end

        // Enable/disable: periods 1,2,0,1 with gen3 disabled
        gens_en      = '0;
        gens_en[3:0] = 4'b0111;
        gens_used    = NGENS'(3);
        program_gen(0, mk(1, 1, 'h100));
        program_gen(1, mk(2, 1, 'h101));
        program_gen(2, mk(0, 1, 'h102));
        program_gen(3, mk(1, 1, 'h103));
        for (int u = 1; u <= 4; u++) begin
            sb.push_back(NTAG'('h100));
            if (u % 2 == 1) sb.push_back(NTAG'('h101));
            pulse();
            wait_idle(1500);
        end

        // Unit 5 with a program request held during the scan
        sb.push_back(NTAG'('h100));
        sb.push_back(NTAG'('h101));
        pulse();
        program_gen(3, mk(1, 1, 'h1F3));
        wait_idle(1500);

        // Program and time_unit together: write first, scan next cycle
        prog_gen_idx = NGENS'(2);
        prog_period  = NPERIOD'(1);
        prog_ticks   = NPERIOD'(1);
        prog_tag     = NTAG'('h1F2);
        prog_v       = 1'b1;
        time_unit    = 1'b1;
        sb.push_back(NTAG'('h100));
        sb.push_back(NTAG'('h1F2));
        @(negedge clk);
        check("simul_prog_a", 32'(prog_a), 1);
        step();
        prog_v    = 1'b0;
        time_unit = 1'b0;
        @(negedge clk);
        check("simul_wait_busy", 32'(busy), 0);
        step();
        @(negedge clk);
        check("simul_start_busy", 32'(busy), 1);
        wait_idle(1500);

        // Unit 7 with gen3 enabled: all four fire, ascending order
        gens_en[3] = 1'b1;
        sb.push_back(NTAG'('h100));
        sb.push_back(NTAG'('h101));
        sb.push_back(NTAG'('h1F2));
        sb.push_back(NTAG'('h1F3));
        pulse();
        wait_idle(1500);

        // Backpressure: 20 pulses stalled, pending saturates at 15
        do_reset();
        for (int i = 0; i < 4; i++) program_gen(i, mk(1, 1, 'h10 + i));
        gens_en      = '0;
        gens_en[3:0] = 4'hF;
        gens_used    = NGENS'(3);
        out_a        = 1'b0;
        for (int k = 0; k < 64; k++) sb.push_back(NTAG'('h10 + (k % 4)));
        for (int p = 1; p <= 20; p++) begin
            pulse();
            step();
            if (p == 16) check("overrun_at_15", 32'(overrun), 0);
            if (p == 17) check("overrun_set", 32'(overrun), 1);
        end
        @(negedge clk);
        check("stall_out_v", 32'(out_v), 1);
        step();
        out_a = 1'b1;
        wait_idle(1500);
        check("overrun_sticky", 32'(overrun), 1);
        check("drain_busy", 32'(busy), 0);

        // Reset while an output is held: output discarded, RAM retained
        out_a = 1'b0;
        sb.push_back(NTAG'('h10));
        pulse();
        pulse();
        pulse();
        step();
        step();
        @(negedge clk);
        check("pre_rst_out_v", 32'(out_v), 1);
        step();
        do_reset();
        @(negedge clk);
        check("mid_rst_out_v", 32'(out_v), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_overrun", 32'(overrun), 0);
        check("mid_rst_out_tag", 32'(out_tag), 0);
        for (int c = 0; c < 5; c++) step();
        @(negedge clk);
        check("mid_rst_no_pending", 32'(busy), 0);
        step();
        out_a = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back(NTAG'('h10 + i));
        pulse();
        wait_idle(1500);

        // Boundaries: ticks=0 fires on first unit, full 256-entry scan
        for (int i = 0; i < 256; i++) begin
            if (i == 0)        program_gen(i, mk(2, 0, 'h0AA));
            else if (i == 255) program_gen(i, mk(1, 0, 'h7FF));
            else               program_gen(i, mk(0, 0, i));
        end
        gens_en   = '1;
        gens_used = NGENS'(255);
        for (int u = 1; u <= 3; u++) begin
            if (u % 2 == 1) sb.push_back(NTAG'('h0AA));
            sb.push_back(NTAG'('h7FF));
            pulse();
            wait_idle(1500);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_spike_generator_array
